// File: rtl/hazard_redirect_ctrl_pkg.sv
// cpu_pkg: forwarding select codes, control FSM states and register constants shared by the hazard controller
package cpu_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [4:0] REG_ZERO  = 5'd0;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd
  );
    return (mem_we && mem_rd != REG_ZERO && mem_rd == src) ? FWD_EXMEM :
           (wb_we && wb_rd != REG_ZERO && wb_rd == src)    ? FWD_MEMWB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_redirect_ctrl_if.sv
// hazard_redirect_ctrl_if: pipeline-register fields in, stall/flush/forward controls and counters out
interface hazard_redirect_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_ra, id_rb, ex_ra, ex_rb, ex_desreg, mem_desreg, wb_desreg;
  logic             id_use_ra, id_use_rb, ex_regwrite, ex_memtoreg, ex_halt, ex_taken;
  logic             mem_regwrite, wb_regwrite;
  logic             pc_stall, ifid_stall, bubble_rst, jump_rst, halted;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;
  modport master (
    output id_ra, id_rb, id_use_ra, id_use_rb, ex_ra, ex_rb, ex_desreg, ex_regwrite,
           ex_memtoreg, ex_halt, ex_taken, mem_desreg, mem_regwrite, wb_desreg, wb_regwrite,
    input  pc_stall, ifid_stall, bubble_rst, jump_rst, fwd_a, fwd_b, halted,
           cyc_cnt, stall_cnt, flush_cnt
  );
  modport slave (
    input  id_ra, id_rb, id_use_ra, id_use_rb, ex_ra, ex_rb, ex_desreg, ex_regwrite,
           ex_memtoreg, ex_halt, ex_taken, mem_desreg, mem_regwrite, wb_desreg, wb_regwrite,
    output pc_stall, ifid_stall, bubble_rst, jump_rst, fwd_a, fwd_b, halted,
           cyc_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_redirect_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; ports clk, rst (sync active-low), en, q
module sat_counter #(parameter int CNT_W = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/hazard_redirect_ctrl.sv
// hazard_redirect_ctrl: forwarding, load-use stall, redirect flush, halt-drain FSM and perf counters; clk/rst (sync active-low) plus pipeline bus
module hazard_redirect_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 2
) (
  input logic                   clk,
  input logic                   rst,
  hazard_redirect_ctrl_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          lu, stall_en, flush_en, cyc_en;
  assign lu = bus.ex_memtoreg && bus.ex_regwrite && bus.ex_desreg != REG_ZERO &&
              ((bus.id_use_ra && bus.id_ra == bus.ex_desreg) ||
               (bus.id_use_rb && bus.id_rb == bus.ex_desreg));
  assign bus.fwd_a = rst ? fwd_sel(bus.ex_ra, bus.mem_regwrite, bus.mem_desreg,
                                   bus.wb_regwrite, bus.wb_desreg) : FWD_RF;
  assign bus.fwd_b = rst ? fwd_sel(bus.ex_rb, bus.mem_regwrite, bus.mem_desreg,
                                   bus.wb_regwrite, bus.wb_desreg) : FWD_RF;
  assign cyc_en = state_q != HALTED;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  // A taken redirect in RUN wins over a load-use stall: the flushed ID instruction needs no bubble
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    stall_en       = 1'b0;
    flush_en       = 1'b0;
    bus.pc_stall   = 1'b0;
    bus.ifid_stall = 1'b0;
    bus.bubble_rst = 1'b0;
    bus.jump_rst   = 1'b0;
    bus.halted     = 1'b0;
    if (rst) begin
      if (state_q == RUN) begin
        flush_en       = bus.ex_taken;
        stall_en       = lu && !bus.ex_taken;
        bus.jump_rst   = bus.ex_taken;
        bus.pc_stall   = stall_en;
        bus.ifid_stall = stall_en;
        bus.bubble_rst = stall_en;
        state_d        = bus.ex_halt ? DRAIN : RUN;
        drain_d        = bus.ex_halt ? DW'(DRAIN_CYC - 1) : drain_q;
      end else if (state_q == DRAIN) begin
        bus.pc_stall   = 1'b1;
        bus.ifid_stall = 1'b1;
        bus.jump_rst   = 1'b1;
        state_d        = drain_q == '0 ? HALTED : DRAIN;
        drain_d        = drain_q == '0 ? drain_q : drain_q - 1'b1;
      end else begin
        bus.pc_stall   = 1'b1;
        bus.ifid_stall = 1'b1;
        bus.bubble_rst = 1'b1;
        bus.halted     = 1'b1;
      end
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_cyc   (.clk(clk), .rst(rst), .en(cyc_en),   .q(bus.cyc_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_stall (.clk(clk), .rst(rst), .en(stall_en), .q(bus.stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush (.clk(clk), .rst(rst), .en(flush_en), .q(bus.flush_cnt));
endmodule
